text_line_fetcher: RTL and testbench
====================================

// Module: text_line_fetcher
// PURPOSE
//  Schedules glyph-row fetches from the shared letter-font block (S,C,O,R,E,T,I,M; 14x14, 6-bit colour index)
//  into a per-scanline line buffer, then serves overlay pixels to the VGA colour mapper.
//  Sits between the VGA controller (DrawX/DrawY, line/frame strobes) and the font source.
//  One fetch burst per scanline inside the text band; pixels stream out with 1-cycle latency.
// PARAMETERS
//  NUM_CHARS  8    character slots per text line (1..16)
//  GLYPH_W    14   glyph width in pixels
//  GLYPH_H    14   glyph height in rows
//  TEXT_X0    16   left pixel column of slot 0
//  TEXT_Y0    8    top scanline of text band
// PORTS
//  Clk          in   1             system clock
//  Reset        in   1             asynchronous, active-high reset
//  line_start   in   1             1-cycle pulse; line_y is the scanline about to be drawn
//  frame_start  in   1             1-cycle pulse per frame (vsync)
//  line_y       in   10            scanline for the fetch triggered by line_start
//  DrawX        in   10            current pixel column
//  char_codes   in   3*NUM_CHARS   slot i code in [3i+2:3i]: 0=S 1=C 2=O 3=R 4=E 5=T 6=I 7=M
//  char_valid   in   NUM_CHARS     1 = slot displayed, 0 = blank (skipped, transparent)
//  glyph_req    out  1             fetch request to font source
//  glyph_sel    out  3             glyph code being fetched
//  glyph_row    out  4             glyph row being fetched (0..GLYPH_H-1)
//  glyph_ack    in   1             font source: glyph_data valid this cycle
//  glyph_data   in   6*GLYPH_W     one glyph row, pixel c in [6c+5:6c]
//  busy         out  1             fetch burst in progress
//  text_on      out  1             overlay pixel opaque
//  text_color   out  6             overlay colour index
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; buffer_valid=0; slot ptr=0; blink counter=0.
//  FSM IDLE: on line_start, if TEXT_Y0 <= line_y < TEXT_Y0+GLYPH_H: latch row=line_y-TEXT_Y0,
//   char_codes, char_valid; clear buffer_valid; slot=0; go SCAN. Else buffer_valid=0, stay IDLE.
//  SCAN: if slot==NUM_CHARS -> DONE. If char_valid[slot]=0 -> buffer row zeroed, slot++ (1 cycle).
//   Else assert glyph_req with glyph_sel=code[slot], glyph_row=row -> WAIT.
//  WAIT: glyph_req held high, sel/row stable until glyph_ack. On ack: store glyph_data in buffer[slot],
//   drop glyph_req next cycle, slot++, -> SCAN. glyph_ack while glyph_req=0 is ignored.
//  DONE: buffer_valid=1 for 1 cycle entry, -> IDLE. busy=1 in SCAN/WAIT/DONE.
//  line_start during SCAN/WAIT (overrun): abort burst, glyph_req deasserts that cycle, buffer_valid
//   stays 0, restart per IDLE rule with new line_y. A late ack for the aborted request is dropped.
//  Pixel path (registered, 1 cycle): for x=DrawX-TEXT_X0 in [0, NUM_CHARS*GLYPH_W):
//   slot=x/GLYPH_W, col=x%GLYPH_W, p=buffer[slot][col]; text_on=buffer_valid && p!=0; text_color=p.
//   Outside range or buffer_valid=0: text_on=0, text_color=0. Column arithmetic 10-bit unsigned;
//   DrawX<TEXT_X0 must not wrap into range.
//  Buffer contents retained between lines; only buffer_valid gates output.
//  Reset mid-burst: immediate return to reset state, glyph_req low asynchronously.
// CONFIGURATION
//  TEXT_BLINK_EN defined: 6-bit frame counter incremented on frame_start (wraps 63->0);
//   text_on additionally gated by counter[5]==0 (32 frames on, 32 off). Fetching unaffected.
//  TEXT_BLINK_EN undefined: no counter; overlay always enabled.
// TESTING
//  Reset asserted mid-WAIT -> glyph_req, busy, text_on = 0 same cycle; FSM IDLE after release.
//  line_y=8, codes S,C,O,R,E, valid=5'b11111, ack 2 cycles after req -> 5 requests, row 0,
//   sel 0..4 in order; busy falls after 5th ack + DONE; DrawX=16 -> next cycle text_on=0 (S row0 col0=0), DrawX=18 -> text_on=1, colour 5.
//  line_y=22 (outside band) -> no glyph_req, buffer_valid=0, text_on=0 for all DrawX.
//  char_valid=8'b1111_0101 -> slots 1,3 skipped without req; pixels in slots 1,3 transparent.
//  line_start during 3rd WAIT -> req drops, stale ack ignored, new burst starts at slot 0 with new row.
//  TEXT_BLINK_EN: 32 frame_start pulses -> text_on forced 0; 32 more -> overlay visible again.

Source files
------------

// File: rtl/text_line_fetcher.sv
// Per-scanline glyph-row fetcher and overlay pixel server for the letter font (S,C,O,R,E,T,I,M).
// Optional blink gating: define TEXT_BLINK_EN.
module text_line_fetcher #(
  parameter int NUM_CHARS = 8,
  parameter int GLYPH_W   = 14,
  parameter int GLYPH_H   = 14,
  parameter int TEXT_X0   = 16,
  parameter int TEXT_Y0   = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   line_start,
  input  logic                   frame_start,
  input  logic [9:0]             line_y,
  input  logic [9:0]             DrawX,
  input  logic [3*NUM_CHARS-1:0] char_codes,
  input  logic [NUM_CHARS-1:0]   char_valid,
  output logic                   glyph_req,
  output logic [2:0]             glyph_sel,
  output logic [3:0]             glyph_row,
  input  logic                   glyph_ack,
  input  logic [6*GLYPH_W-1:0]   glyph_data,
  output logic                   busy,
  output logic                   text_on,
  output logic [5:0]             text_color,
  output logic [1:0]             state_dbg
);

  localparam int SLOT_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam int CNT_W  = $clog2(NUM_CHARS + 1);
  localparam int COL_W  = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int SPAN   = NUM_CHARS * GLYPH_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       slot_q;
  logic [SLOT_W-1:0]      slot_idx;
  logic [3:0]             row_q;
  logic [3*NUM_CHARS-1:0] codes_q;
  logic [NUM_CHARS-1:0]   valid_q;
  logic                   req_q;
  logic                   buffer_valid;
  logic [6*GLYPH_W-1:0]   buffer [NUM_CHARS];

  logic in_band;
  logic start_burst, clear_valid, skip_slot, issue_req, take_ack, set_valid;

  assign in_band   = (line_y >= 10'(TEXT_Y0)) && (line_y < 10'(TEXT_Y0 + GLYPH_H));
  assign slot_idx  = slot_q[SLOT_W-1:0];
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  // Font handshake: glyph_req rises with sel/row and holds them stable until the
  // cycle glyph_ack is seen; a new line_start withdraws the request in that same cycle.
  assign glyph_req = req_q & ~line_start;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_burst = 1'b0;
    clear_valid = 1'b0;
    skip_slot   = 1'b0;
    issue_req   = 1'b0;
    take_ack    = 1'b0;
    set_valid   = 1'b0;
    if (line_start) begin
      // Any new line (including an overrun) invalidates the buffer and restarts.
      clear_valid = 1'b1;
      if (in_band) begin
        start_burst = 1'b1;
        state_d     = SCAN;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        SCAN: begin
          if (slot_q == CNT_W'(NUM_CHARS)) state_d = DONE;
          else if (!valid_q[slot_idx])     skip_slot = 1'b1;
          else begin
            issue_req = 1'b1;
            state_d   = WAIT;
          end
        end
        WAIT: begin
          if (glyph_ack) begin
            take_ack = 1'b1;
            state_d  = SCAN;
          end
        end
        DONE: begin
          set_valid = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      slot_q       <= '0;
      row_q        <= '0;
      codes_q      <= '0;
      valid_q      <= '0;
      req_q        <= 1'b0;
      glyph_sel    <= '0;
      glyph_row    <= '0;
      buffer_valid <= 1'b0;
    end else begin
      if (start_burst) begin
        row_q   <= 4'(line_y - 10'(TEXT_Y0));
        codes_q <= char_codes;
        valid_q <= char_valid;
        slot_q  <= '0;
      end else if (skip_slot || take_ack) begin
        slot_q <= slot_q + 1'b1;
      end

      if (clear_valid)    buffer_valid <= 1'b0;
      else if (set_valid) buffer_valid <= 1'b1;

      if (issue_req) begin
        req_q     <= 1'b1;
        glyph_sel <= codes_q[int'(slot_idx) * 3 +: 3];
        glyph_row <= row_q;
      end else if (take_ack || line_start) begin
        req_q <= 1'b0;
      end
    end
  end

  // Line buffer keeps its contents across lines; buffer_valid alone gates output.
  always_ff @(posedge Clk) begin
    if (take_ack)       buffer[slot_idx] <= glyph_data;
    else if (skip_slot) buffer[slot_idx] <= '0;
  end

  logic [9:0]         px_x, px_slot, px_col;
  logic               px_in_range;
  logic [SLOT_W-1:0]  pslot;
  logic [COL_W-1:0]   pcol;
  logic [6*GLYPH_W-1:0] row_word;
  logic [5:0]         pixel;
  logic               blink_on;
  logic               unused_bits;

  // DrawX below TEXT_X0 is rejected explicitly so the wrapped difference never lands in range.
  assign px_x        = DrawX - 10'(TEXT_X0);
  assign px_in_range = (DrawX >= 10'(TEXT_X0)) && (px_x < 10'(SPAN));
  assign px_slot     = px_x / 10'(GLYPH_W);
  assign px_col      = px_x % 10'(GLYPH_W);
  assign pslot       = px_in_range ? px_slot[SLOT_W-1:0] : '0;
  assign pcol        = px_in_range ? px_col[COL_W-1:0]   : '0;
  assign row_word    = buffer[pslot];
  assign pixel       = row_word[int'(pcol) * 6 +: 6];
  assign unused_bits = ^{px_slot[9:SLOT_W], px_col[9:COL_W]};

`ifdef TEXT_BLINK_EN
  logic [5:0] blink_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)            blink_cnt <= '0;
    else if (frame_start) blink_cnt <= blink_cnt + 6'd1;
  end

  assign blink_on = ~blink_cnt[5];
`else
  logic unused_frame;

  assign unused_frame = frame_start;
  assign blink_on     = 1'b1;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      text_on    <= 1'b0;
      text_color <= '0;
    end else begin
      text_on    <= buffer_valid && px_in_range && (pixel != 6'd0) && blink_on;
      text_color <= (buffer_valid && px_in_range) ? pixel : 6'd0;
    end
  end

endmodule

// File: tb/tb_text_line_fetcher.sv
// Directed bench for text_line_fetcher: font responder, request scoreboard and line-buffer model.
module tb_text_line_fetcher;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        line_start, frame_start;
  logic [9:0]  line_y, DrawX;
  logic [23:0] char_codes;
  logic [7:0]  char_valid;
  logic        glyph_req;
  logic [2:0]  glyph_sel;
  logic [3:0]  glyph_row;
  logic        glyph_ack;
  logic [83:0] glyph_data;
  logic        busy, text_on;
  logic [5:0]  text_color;
  logic [1:0]  state_dbg;

  text_line_fetcher dut (
    .Clk(Clk), .Reset(Reset), .line_start(line_start), .frame_start(frame_start),
    .line_y(line_y), .DrawX(DrawX), .char_codes(char_codes), .char_valid(char_valid),
    .glyph_req(glyph_req), .glyph_sel(glyph_sel), .glyph_row(glyph_row),
    .glyph_ack(glyph_ack), .glyph_data(glyph_data), .busy(busy),
    .text_on(text_on), .text_color(text_color), .state_dbg(state_dbg)
  );

  always #5 Clk = ~Clk;

  int         checks = 0;
  int         failures = 0;
  int         frames = 0;
  logic       bv = 1'b0;
  logic [10:0] exp_q[$];
  logic [5:0] exp_buf [8][14];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [5:0] font_px(input int code, input int row, input int col);
    if (col == 0) return 6'd0;
    return 6'((code * 5 + row * 3 + col + 3) % 64);
  endfunction

  function automatic logic [83:0] font_row(input int code, input int row);
    logic [83:0] r;
    for (int c = 0; c < 14; c++) r[6*c +: 6] = font_px(code, row, c);
    return r;
  endfunction

  function automatic bit blink_exp();
`ifdef TEXT_BLINK_EN
    return ((frames >> 5) & 1) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic expect_line(input int y, input logic [23:0] codes, input logic [7:0] valid);
    exp_q.delete();
    bv = 1'b0;
    if (y >= 8 && y < 22) begin
      for (int s = 0; s < 8; s++) begin
        if (valid[s]) exp_q.push_back({4'(s), codes[3*s +: 3], 4'(y - 8)});
        else for (int c = 0; c < 14; c++) exp_buf[s][c] = 6'd0;
      end
    end
  endtask

  task automatic start_line(input int y, input logic [23:0] codes, input logic [7:0] valid);
    char_codes = codes;
    char_valid = valid;
    line_y     = 10'(y);
    line_start = 1'b1;
    tick;
    line_start = 1'b0;
    expect_line(y, codes, valid);
  endtask

  task automatic wait_req;
    int n = 0;
    while (!glyph_req && n < 30) begin
      tick;
      n++;
    end
    check("req_timeout", glyph_req, 1);
  endtask

  task automatic serve_one(input bit deliver);
    logic [10:0] e;
    wait_req;
    if (exp_q.size() == 0) begin
      check("unexpected_req", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check("req_sel", glyph_sel, e[6:4]);
    check("req_row", glyph_row, e[3:0]);
    if (!deliver) return;
    tick;
    check("req_hold", glyph_req, 1);
    tick;
    glyph_ack  = 1'b1;
    glyph_data = font_row(e[6:4], e[3:0]);
    for (int c = 0; c < 14; c++) exp_buf[e[10:7]][c] = font_px(e[6:4], e[3:0], c);
    tick;
    glyph_ack = 1'b0;
    check("req_drop", glyph_req, 0);
  endtask

  task automatic serve_all;
    while (exp_q.size() > 0) serve_one(1'b1);
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 40) begin
      tick;
      n++;
    end
    check("busy_timeout", busy, 0);
    check("idle_state", state_dbg, 0);
    bv = 1'b1;
  endtask

  task automatic check_px(input int dx);
    int x;
    bit inr;
    logic [5:0] p;
    DrawX = 10'(dx);
    tick;
    x   = dx - 16;
    inr = (dx >= 16) && (dx < 16 + 112);
    p   = inr ? exp_buf[x / 14][x % 14] : 6'd0;
    check($sformatf("px_on_%0d", dx), text_on, 32'(bv && inr && (p != 0) && blink_exp()));
    check($sformatf("px_col_%0d", dx), text_color, (bv && inr) ? 32'(p) : 32'd0);
  endtask

  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
      frames++;
    end
  endtask

  initial begin
    logic [23:0] codes;
    logic [10:0] e;
    for (int s = 0; s < 8; s++)
      for (int c = 0; c < 14; c++) exp_buf[s][c] = 6'd0;

    Reset = 1'b1; line_start = 0; frame_start = 0; line_y = 0; DrawX = 0;
    char_codes = 0; char_valid = 0; glyph_ack = 0; glyph_data = 0;
    #12;
    check("rst_req", glyph_req, 0);
    check("rst_busy", busy, 0);
    check("rst_on", text_on, 0);
    check("rst_col", text_color, 0);
    check("rst_sel", glyph_sel, 0);
    check("rst_row", glyph_row, 0);
    check("rst_state", state_dbg, 0);
    @(negedge Clk);
    Reset = 1'b0;
    tick;

    // Row 0 of S,C,O,R,E in slots 0..4.
    start_line(8, {3'd7, 3'd7, 3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 8'b0001_1111);
    check("burst_busy", busy, 1);
    serve_all;
    wait_idle;
    check_px(16);
    check_px(18);
    check("s_row0_col2", text_color, 6'd5);
    check_px(15);
    check_px(5);
    check_px(40);
    check_px(73);
    check_px(100);
    check_px(127);
    check_px(128);

    pulse_frames(32);
    check_px(18);
    pulse_frames(32);
    check_px(18);

    // Out of band: no fetch, overlay off.
    start_line(22, 24'h0, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      check("oob_req", glyph_req, 0);
      check("oob_busy", busy, 0);
      tick;
    end
    check_px(18);
    check_px(30);
    check_px(90);

    // Sparse slots: 1 and 3 are skipped.
    codes = '0;
    for (int s = 0; s < 8; s++) codes[3*s +: 3] = 3'($urandom_range(0, 7));
    start_line(13, codes, 8'b1111_0101);
    serve_all;
    wait_idle;
    check_px(20);
    check_px(31);
    check_px(35);
    check_px(46);
    check_px(60);
    check_px(76);
    check_px(125);

    // Overrun during the third WAIT.
    for (int s = 0; s < 8; s++) codes[3*s +: 3] = 3'($urandom_range(0, 7));
    start_line(9, codes, 8'hFF);
    serve_one(1'b1);
    serve_one(1'b1);
    serve_one(1'b0);
    tick;
    for (int s = 0; s < 8; s++) codes[3*s +: 3] = 3'(7 - s);
    char_codes = codes;
    line_y     = 10'd12;
    line_start = 1'b1;
    #1;
    check("abort_req_low", glyph_req, 0);
    tick;
    line_start = 1'b0;
    expect_line(12, codes, 8'hFF);
    check("abort_restart_busy", busy, 1);
    glyph_ack  = 1'b1;
    glyph_data = {84{1'b1}};
    tick;
    glyph_ack  = 1'b0;
    e = exp_q[0];
    check("restart_slot0", e[10:7], 0);
    serve_all;
    wait_idle;
    check_px(17);
    check_px(29);
    check_px(50);
    check_px(110);

    // Reset while a request is outstanding.
    start_line(10, codes, 8'hFF);
    wait_req;
    #2;
    Reset = 1'b1;
    #1;
    check("mid_rst_req", glyph_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_on", text_on, 0);
    check("mid_rst_state", state_dbg, 0);
    @(negedge Clk);
    Reset = 1'b0;
    exp_q.delete();
    bv     = 1'b0;
    frames = 0;
    tick;
    check("post_rst_state", state_dbg, 0);
    check("post_rst_req", glyph_req, 0);
    check_px(18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
